// File: rtl/gf2549_pkg.sv
// Shared constants and types for GF(2549) arithmetic.
package gf2549_pkg;
  localparam int unsigned Q      = 2549;
  localparam int unsigned W_OP   = 12;
  localparam int unsigned W_PROD = 23;

  typedef logic [W_OP-1:0]   elem_t;
  typedef logic [W_PROD-1:0] prod_t;

  // Modulus in operand width, for range compares without width mixing.
  localparam elem_t Q_ELEM = elem_t'(Q);
endpackage

// File: rtl/barret_for_2549.sv
// Combinational Barrett reduction of a 23-bit value modulo 2549.
// The quotient estimate uses mu = floor(2^24 / 2549) = 6581. Because the
// shift (24) exceeds the input width (23), the estimate is at most 2 low.
// The partial remainder is therefore below 3*Q, and two conditional
// subtractions bring it into 0..Q-1.
module barret_for_2549
  import gf2549_pkg::*;
(
  input  prod_t din_a,
  output elem_t dout_r
);
  localparam logic [36:0] MU  = 37'd6581;
  localparam logic [13:0] Q14 = 14'(Q);

  logic [12:0] q_est;
  prod_t       q_times_q;
  logic [13:0] r0, r1, r2;

  // Estimate quotient, form partial remainder, then correct it twice.
  always_comb begin
    q_est     = 13'((37'(din_a) * MU) >> 24);
    q_times_q = prod_t'(q_est) * prod_t'(Q);
    r0        = 14'(din_a - q_times_q);
    r1        = (r0 >= Q14) ? (r0 - Q14) : r0;
    r2        = (r1 >= Q14) ? (r1 - Q14) : r1;
    dout_r    = r2[11:0];
  end
endmodule

// File: rtl/modmul_2549_pipe.sv
// Two-stage streaming modular multiplier over GF(2549).
// S1 holds the raw product and the range-error flag; S2 holds the reduced
// result. Outputs are driven directly from S2 registers.
//
// Handshake: a transfer occurs on a rising edge where valid & ready are both
// high. Once valid is raised it stays high with stable data until the
// transfer. in_ready depends only on internal state and out_ready, never on
// in_valid.
module modmul_2549_pipe
  import gf2549_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_a,
  input  logic [11:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_r,
  output logic        out_err
);
  logic  s1_valid;
  prod_t s1_prod;
  logic  s1_err;

  logic  s2_valid;
  elem_t s2_r;
  logic  s2_err;

  elem_t red_r;
  logic  adv2;
  logic  in_xfer;
  logic  out_xfer;

  barret_for_2549 u_barrett (
    .din_a  (s1_prod),
    .dout_r (red_r)
  );

  // Advance S1 into S2 only when S2 is empty or is being drained this cycle.
  always_comb begin
    adv2     = s1_valid & (~s2_valid | out_ready);
    in_ready = ~s1_valid | adv2;
    in_xfer  = in_valid & in_ready;
    out_xfer = s2_valid & out_ready;
  end

  // Stage 1: capture product and range flag on input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_err   <= 1'b0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_prod  <= prod_t'(in_a) * prod_t'(in_b);
      s1_err   <= (in_a >= Q_ELEM) | (in_b >= Q_ELEM);
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: capture reduced result; an errored pair yields zero, so an
  // unreduced value can never appear on out_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_r     <= '0;
      s2_err   <= 1'b0;
    end else if (adv2) begin
      s2_valid <= 1'b1;
      s2_r     <= s1_err ? '0 : red_r;
      s2_err   <= s1_err;
    end else if (out_xfer) begin
      s2_valid <= 1'b0;
    end
  end

  // Outputs straight from S2 registers.
  always_comb begin
    out_valid = s2_valid;
    out_r     = s2_r;
    out_err   = s2_err;
  end
endmodule

// File: tb/tb_modmul_2549_pipe.sv
// Testbench for modmul_2549_pipe: directed vector table plus hand-written
// latency, streaming, backpressure, error and reset sequences.
module tb_modmul_2549_pipe;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_a;
  logic [11:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_r;
  logic        out_err;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int stall_cnt = 0;
  int out_cnt   = 0;

  logic [12:0] exp_q[$];

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] r;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  modmul_2549_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_err   (out_err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Driver: call at a negedge; offers one pair until accepted and returns
  // at the negedge after the accepting edge.
  task automatic send(input logic [11:0] a, input logic [11:0] b,
                      input logic [11:0] r, input logic e);
    int tries = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    #1;
    while (!in_ready && tries < 100) begin
      stall_cnt++;
      @(negedge clk); #1;
      tries++;
    end
    if (!in_ready) begin
      check_cnt++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 (a=%0d b=%0d)", a, b);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back({e, r});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Scoreboard: every output transfer is compared against the expected queue.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        check_cnt++;
        $display("FAIL unexpected_output: got r=%0d err=%0d expected none", out_r, out_err);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        chk("out_r", int'(out_r), int'(e[11:0]));
        chk("out_err", int'(out_err), int'(e[12]));
      end
    end
  end

  initial begin
    vecs[0] = '{a: 12'd100,  b: 12'd100,  r: 12'd2353, err: 1'b0};
    vecs[1] = '{a: 12'd2548, b: 12'd2548, r: 12'd1,    err: 1'b0};
    vecs[2] = '{a: 12'd0,    b: 12'd2548, r: 12'd0,    err: 1'b0};
    vecs[3] = '{a: 12'd1,    b: 12'd2548, r: 12'd2548, err: 1'b0};
    vecs[4] = '{a: 12'd1234, b: 12'd2,    r: 12'd2468, err: 1'b0};
    vecs[5] = '{a: 12'd50,   b: 12'd51,   r: 12'd1,    err: 1'b0};
    vecs[6] = '{a: 12'd2000, b: 12'd2000, r: 12'd619,  err: 1'b0};
    vecs[7] = '{a: 12'd4095, b: 12'd4095, r: 12'd0,    err: 1'b1};
    vecs[8] = '{a: 12'd7,    b: 12'd2549, r: 12'd0,    err: 1'b1};
    vecs[9] = '{a: 12'd2549, b: 12'd2549, r: 12'd0,    err: 1'b1};

    // Reset
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_r", int'(out_r), 0);
    chk("rst_out_err", int'(out_err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);

    // T1: latency of a single op
    in_a = 12'd100; in_b = 12'd100; in_valid = 1'b1;
    #1;
    chk("t1_in_ready", int'(in_ready), 1);
    exp_q.push_back({1'b0, 12'd2353});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t1_valid_edge1", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("t1_valid_edge2", int'(out_valid), 1);
    chk("t1_r_edge2", int'(out_r), 2353);
    @(negedge clk);
    @(negedge clk);

    // T2 + table: directed vectors, back-to-back
    for (int i = 0; i < 10; i++) send(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].err);
    repeat (4) @(negedge clk);
    chk("table_drained", exp_q.size(), 0);

    // T3: streaming a=i, b=1
    stall_cnt = 0;
    out_cnt   = 0;
    for (int i = 0; i < 2549; i++) send(12'(i), 12'd1, 12'(i), 1'b0);
    repeat (3) @(negedge clk);
    chk("t3_stalls", stall_cnt, 0);
    chk("t3_out_count", out_cnt, 2549);
    chk("t3_drained", exp_q.size(), 0);

    // T4: backpressure
    out_ready = 1'b0;
    send(12'd10, 12'd20, 12'd200, 1'b0);
    send(12'd30, 12'd40, 12'd1200, 1'b0);
    in_a = 12'd50; in_b = 12'd60; in_valid = 1'b1;
    #1;
    chk("t4_in_ready_full", int'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("t4_stall_valid", int'(out_valid), 1);
      chk("t4_stall_r", int'(out_r), 200);
      chk("t4_stall_in_ready", int'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    send(12'd50, 12'd60, 12'd451, 1'b0);
    repeat (4) @(negedge clk);
    chk("t4_drained", exp_q.size(), 0);

    // T5: range error followed by a legal pair
    send(12'd2549, 12'd7, 12'd0, 1'b0 | 1'b1);
    send(12'd3, 12'd4, 12'd12, 1'b0);
    repeat (4) @(negedge clk);
    chk("t5_drained", exp_q.size(), 0);

    // T6: reset with both stages full
    out_ready = 1'b0;
    send(12'd7, 12'd8, 12'd56, 1'b0);
    send(12'd9, 12'd9, 12'd81, 1'b0);
    #1;
    chk("t6_full_valid", int'(out_valid), 1);
    chk("t6_full_in_ready", int'(in_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", int'(out_valid), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("t6_no_output", int'(out_valid), 0);
    end
    @(negedge clk);
    send(12'd5, 12'd6, 12'd30, 1'b0);

    // Final drain, bounded
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("final_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
